// File: rtl/fetch_stage.sv
// Instruction fetch stage: drives the icache and fills the IF/ID register,
// with a one-entry skid buffer so the word arriving during a stall is not lost.
module fetch_stage #(
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] iaddr,
    input  logic        ihit,
    input  logic [31:0] imemload,
    input  logic        halt,
    input  logic        flush,
    input  logic        stall,
    output logic        imemREN,
    output logic [31:0] imemaddr,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc4,
    output logic        ifid_valid,
    output logic        halted
);

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        bufFull_q, bufFull_d;
    logic [31:0] bufInstr_q, bufInstr_d;
    logic [31:0] bufPc4_q, bufPc4_d;
    logic [31:0] ifidInstr_q, ifidInstr_d;
    logic [31:0] ifidPc4_q, ifidPc4_d;
    logic        ifidValid_q, ifidValid_d;

    logic        fetchHit;
    logic [31:0] pc4;

    // A returned word only counts when the cache was actually being read.
    assign imemREN  = (state_q != HALTED) && !bufFull_q;
    assign fetchHit = ihit && imemREN;
    assign pc4      = iaddr + 32'd4;
    assign imemaddr = iaddr;

    assign ifid_instr = ifidInstr_q;
    assign ifid_pc4   = ifidPc4_q;
    assign ifid_valid = ifidValid_q;
    assign halted     = (state_q == HALTED);

    always_comb begin
        state_d     = state_q;
        bufFull_d   = bufFull_q;
        bufInstr_d  = bufInstr_q;
        bufPc4_d    = bufPc4_q;
        ifidInstr_d = ifidInstr_q;
        ifidPc4_d   = ifidPc4_q;
        ifidValid_d = ifidValid_q;

        if (halt) begin
            state_d     = HALTED;
            bufFull_d   = 1'b0;
            ifidInstr_d = NOP_WORD;
            ifidPc4_d   = 32'h0;
            ifidValid_d = 1'b0;
        end else if (state_q == HALTED) begin
            state_d = HALTED;
        end else if (flush) begin
            // An outstanding miss must be absorbed in DRAIN so its wrong-path word is dropped.
            state_d     = (imemREN && !ihit) ? DRAIN : FETCH;
            bufFull_d   = 1'b0;
            ifidInstr_d = NOP_WORD;
            ifidPc4_d   = 32'h0;
            ifidValid_d = 1'b0;
        end else if (state_q == DRAIN) begin
            ifidInstr_d = NOP_WORD;
            ifidPc4_d   = 32'h0;
            ifidValid_d = 1'b0;
            if (fetchHit) begin
                state_d = FETCH;
            end
        end else if (stall) begin
            if (!bufFull_q && fetchHit) begin
                bufFull_d  = 1'b1;
                bufInstr_d = imemload;
                bufPc4_d   = pc4;
            end
        end else if (bufFull_q) begin
            bufFull_d   = 1'b0;
            ifidInstr_d = bufInstr_q;
            ifidPc4_d   = bufPc4_q;
            ifidValid_d = 1'b1;
        end else if (fetchHit) begin
            ifidInstr_d = imemload;
            ifidPc4_d   = pc4;
            ifidValid_d = 1'b1;
        end else begin
            ifidInstr_d = NOP_WORD;
            ifidPc4_d   = 32'h0;
            ifidValid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= FETCH;
            bufFull_q   <= 1'b0;
            bufInstr_q  <= 32'h0;
            bufPc4_q    <= 32'h0;
            ifidInstr_q <= NOP_WORD;
            ifidPc4_q   <= 32'h0;
            ifidValid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bufFull_q   <= bufFull_d;
            bufInstr_q  <= bufInstr_d;
            bufPc4_q    <= bufPc4_d;
            ifidInstr_q <= ifidInstr_d;
            ifidPc4_q   <= ifidPc4_d;
            ifidValid_q <= ifidValid_d;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios followed by random
// traffic, all compared against a queue-based behavioural model.
module tb_fetch_stage;

    localparam logic [31:0] TbNop = 32'h0000_0013;

    logic        CLK = 1'b0;
    logic        RST;
    logic [31:0] iaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic        halt;
    logic        flush;
    logic        stall;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc4;
    logic        ifid_valid;
    logic        halted;

    int errors = 0;
    int checks = 0;

    // Behavioural model: a pending-word queue plus draining/halted flags.
    logic        mHalted;
    logic        mDraining;
    logic [63:0] mBufQ[$];
    logic [31:0] mInstr;
    logic [31:0] mPc4;
    logic        mValid;

    fetch_stage #(.NOP_WORD(TbNop)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .iaddr      (iaddr),
        .ihit       (ihit),
        .imemload   (imemload),
        .halt       (halt),
        .flush      (flush),
        .stall      (stall),
        .imemREN    (imemREN),
        .imemaddr   (imemaddr),
        .ifid_instr (ifid_instr),
        .ifid_pc4   (ifid_pc4),
        .ifid_valid (ifid_valid),
        .halted     (halted)
    );

    always #5 CLK = ~CLK;

    function automatic logic modelRen();
        return !mHalted && (mBufQ.size() == 0);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        mHalted   = 1'b0;
        mDraining = 1'b0;
        mBufQ.delete();
        mInstr    = TbNop;
        mPc4      = 32'h0;
        mValid    = 1'b0;
    endtask

    task automatic modelBubble();
        mInstr = TbNop;
        mPc4   = 32'h0;
        mValid = 1'b0;
    endtask

    task automatic modelStep();
        logic        ren;
        logic        hitEff;
        logic [63:0] ent;
        ren    = modelRen();
        hitEff = ihit && ren;
        if (halt) begin
            mHalted   = 1'b1;
            mDraining = 1'b0;
            mBufQ.delete();
            modelBubble();
        end else if (mHalted) begin
            // nothing moves until reset
        end else if (flush) begin
            mBufQ.delete();
            modelBubble();
            mDraining = ren && !ihit;
        end else if (mDraining) begin
            modelBubble();
            if (hitEff) mDraining = 1'b0;
        end else if (stall) begin
            if (hitEff) mBufQ.push_back({imemload, iaddr + 32'd4});
        end else if (mBufQ.size() != 0) begin
            ent    = mBufQ.pop_front();
            mInstr = ent[63:32];
            mPc4   = ent[31:0];
            mValid = 1'b1;
        end else if (hitEff) begin
            mInstr = imemload;
            mPc4   = iaddr + 32'd4;
            mValid = 1'b1;
        end else begin
            modelBubble();
        end
    endtask

    task automatic checkRegs(input string tag);
        checkOutput({tag, ":instr"}, ifid_instr, mInstr);
        checkOutput({tag, ":pc4"}, ifid_pc4, mPc4);
        checkOutput({tag, ":valid"}, {31'h0, ifid_valid}, {31'h0, mValid});
        checkOutput({tag, ":halted"}, {31'h0, halted}, {31'h0, mHalted});
    endtask

    // Inputs change just after an edge; outputs are sampled 1 time unit after edges.
    task automatic applyStimulus(input logic h, input logic f, input logic s,
                                 input logic hi, input logic [31:0] addr,
                                 input logic [31:0] load);
        halt     = h;
        flush    = f;
        stall    = s;
        ihit     = hi;
        iaddr    = addr;
        imemload = load;
        #1;
        checkOutput("imemREN", {31'h0, imemREN}, {31'h0, modelRen()});
        checkOutput("imemaddr", imemaddr, addr);
        modelStep();
        @(posedge CLK);
        #1;
        checkRegs("step");
    endtask

    task automatic doReset();
        RST = 1'b1;
        #1;
        modelReset();
        checkRegs("async_reset");
        checkOutput("reset_ren", {31'h0, imemREN}, 32'h1);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        #1;
        checkOutput("post_reset_ren", {31'h0, imemREN}, 32'h1);
    endtask

    initial begin
        RST      = 1'b1;
        halt     = 1'b0;
        flush    = 1'b0;
        stall    = 1'b0;
        ihit     = 1'b0;
        iaddr    = 32'h0;
        imemload = 32'h0;
        modelReset();
        #2;
        checkRegs("reset");
        checkOutput("reset_ren", {31'h0, imemREN}, 32'h1);
        @(posedge CLK);
        #1;
        RST = 1'b0;

        // First fetch after reset release
        applyStimulus(0, 0, 0, 1, 32'h0, 32'h8C01_0004);
        checkOutput("first_instr", ifid_instr, 32'h8C01_0004);
        checkOutput("first_pc4", ifid_pc4, 32'h4);
        checkOutput("first_valid", {31'h0, ifid_valid}, 32'h1);

        // Three-cycle stall; word arriving on the first is buffered
        applyStimulus(0, 0, 1, 1, 32'h4, 32'h0022_1820);
        checkOutput("stall_hold", ifid_instr, 32'h8C01_0004);
        checkOutput("stall_ren2", {31'h0, imemREN}, 32'h0);
        applyStimulus(0, 0, 1, 1, 32'h8, 32'h1111_1111);
        checkOutput("stall_ren3", {31'h0, imemREN}, 32'h0);
        applyStimulus(0, 0, 1, 1, 32'h8, 32'h2222_2222);
        applyStimulus(0, 0, 0, 0, 32'h8, 32'h0);
        checkOutput("unstall_instr", ifid_instr, 32'h0022_1820);
        checkOutput("unstall_valid", {31'h0, ifid_valid}, 32'h1);

        // Flush with a miss outstanding; the late word must be dropped
        applyStimulus(0, 0, 0, 0, 32'h8, 32'h0);
        applyStimulus(0, 1, 0, 0, 32'h8, 32'h0);
        applyStimulus(0, 0, 0, 0, 32'h8, 32'h0);
        applyStimulus(0, 0, 0, 1, 32'h8, 32'hDEAD_BEEF);
        checkOutput("drain_valid", {31'h0, ifid_valid}, 32'h0);
        checkOutput("drain_no_beef", {31'h0, ifid_instr == 32'hDEAD_BEEF}, 32'h0);
        applyStimulus(0, 0, 0, 1, 32'h40, 32'h2002_000A);
        checkOutput("after_drain", ifid_instr, 32'h2002_000A);

        // Flush and stall together while the buffer is full
        applyStimulus(0, 0, 1, 1, 32'h44, 32'hA1A1_A1A1);
        applyStimulus(0, 1, 1, 0, 32'h48, 32'h0);
        checkOutput("flush_stall_valid", {31'h0, ifid_valid}, 32'h0);
        checkOutput("flush_stall_ren", {31'h0, imemREN}, 32'h1);
        applyStimulus(0, 0, 0, 0, 32'h48, 32'h0);

        // PC+4 wraps around the top of the address space
        applyStimulus(0, 0, 0, 1, 32'hFFFF_FFFC, 32'h1234_5678);
        checkOutput("wrap_pc4", ifid_pc4, 32'h0);

        // Halt is sticky until reset
        applyStimulus(1, 0, 0, 0, 32'h0, 32'h0);
        checkOutput("halt_ren", {31'h0, imemREN}, 32'h0);
        applyStimulus(0, 1, 0, 1, 32'h10, 32'h5555_5555);
        applyStimulus(0, 0, 1, 1, 32'h14, 32'h6666_6666);
        applyStimulus(0, 0, 0, 1, 32'h18, 32'h7777_7777);
        checkOutput("halt_sticky", {31'h0, halted}, 32'h1);
        doReset();

        // Reset mid-stall with a full buffer, then mid-drain
        applyStimulus(0, 0, 1, 1, 32'h100, 32'hCAFE_0001);
        doReset();
        applyStimulus(0, 0, 0, 1, 32'h200, 32'hCAFE_0002);
        checkOutput("reset_stall_fetch", ifid_instr, 32'hCAFE_0002);
        applyStimulus(0, 1, 0, 0, 32'h204, 32'h0);
        doReset();
        applyStimulus(0, 0, 0, 1, 32'h300, 32'hCAFE_0003);
        checkOutput("reset_drain_fetch", ifid_instr, 32'hCAFE_0003);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            if ((mHalted && $urandom_range(0, 3) == 0) || $urandom_range(0, 99) == 0) begin
                doReset();
            end else begin
                applyStimulus($urandom_range(0, 49) == 0,
                              $urandom_range(0, 7) == 0,
                              $urandom_range(0, 2) == 0,
                              $urandom_range(0, 1) == 1,
                              $urandom,
                              $urandom);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
